// File: rtl/multdiv_ctrl_pkg.sv
// Shared constants and types for the multiply/divide pipeline controller.
package multdiv_ctrl_pkg;

    // Instruction field encodings
    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MUL   = 5'b00110;
    localparam logic [4:0] ALU_DIV   = 5'b00111;

    // Cycle counter width and the BUSY count at which the unit is declared hung
    localparam int         CNT_W      = 6;
    localparam logic [5:0] MD_TIMEOUT = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_e;

    // True when the instruction is an R-type with the given ALU op field
    function automatic logic is_rtype_op(input logic [31:0] insn, input logic [4:0] alu_op);
        return (insn[31:27] == OPC_RTYPE) && (insn[6:2] == alu_op);
    endfunction

endpackage

// File: rtl/md_cycle_counter.sv
// Free-running BUSY-cycle counter with synchronous clear, enable and a
// terminal-count flag used to time out a multdiv unit that never answers.
module md_cycle_counter
    import multdiv_ctrl_pkg::*;
#(
    parameter int             W        = CNT_W,
    parameter logic [W-1:0]   TERMINAL = MD_TIMEOUT
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [W-1:0] count_reg;

    // Clear has priority over counting so START always hands BUSY a zero count
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign terminal = (count_reg == TERMINAL);

endmodule

// File: rtl/multdiv_ctrl.sv
// Pipeline-side controller for a multi-cycle multiply/divide unit: detects a
// mult/div in execute, latches operands, pulses start, stalls the front of the
// pipe until the unit answers (or times out) and presents the result for X/M.
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] insn_x,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result,
    output logic        exception
);

    md_state_e   state_reg;
    logic [31:0] md_a_reg;
    logic [31:0] md_b_reg;
    logic        ctrl_mult_reg;
    logic        ctrl_div_reg;
    logic        result_valid_reg;
    logic [31:0] result_reg;
    logic        exception_reg;
    logic        cnt_terminal;

    logic is_mult;
    logic is_div;
    logic is_md;

    // Register-number and shamt fields play no part in the decode
    logic unused_insn_bits;
    assign unused_insn_bits = ^{insn_x[26:7], insn_x[1:0]};

    assign is_mult = is_rtype_op(insn_x, ALU_MUL);
    assign is_div  = is_rtype_op(insn_x, ALU_DIV);
    assign is_md   = is_mult | is_div;

    md_cycle_counter #(
        .W        (CNT_W),
        .TERMINAL (MD_TIMEOUT)
    ) u_cycle_counter (
        .clk      (clock),
        .srst     (reset),
        .clear    (state_reg == ST_START),
        .enable   (state_reg == ST_BUSY),
        .terminal (cnt_terminal)
    );

    // Control FSM; start pulses and result_valid are registered on the
    // transition into the state in which they must be seen. The start-pulse
    // registers are loaded from the decode in IDLE, so they carry the op type.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            md_a_reg         <= '0;
            md_b_reg         <= '0;
            ctrl_mult_reg    <= 1'b0;
            ctrl_div_reg     <= 1'b0;
            result_valid_reg <= 1'b0;
            result_reg       <= '0;
            exception_reg    <= 1'b0;
        end else begin
            ctrl_mult_reg    <= 1'b0;
            ctrl_div_reg     <= 1'b0;
            result_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (is_md) begin
                        md_a_reg      <= operand_a;
                        md_b_reg      <= operand_b;
                        ctrl_mult_reg <= is_mult;
                        ctrl_div_reg  <= is_div;
                        state_reg     <= ST_START;
                    end
                end
                ST_START: begin
                    state_reg <= ST_BUSY;
                end
                ST_BUSY: begin
                    // A real answer beats the timeout when both land together
                    if (md_ready) begin
                        result_reg       <= md_result;
                        exception_reg    <= md_exception;
                        result_valid_reg <= 1'b1;
                        state_reg        <= ST_DONE;
                    end else if (cnt_terminal) begin
                        result_reg       <= '0;
                        exception_reg    <= 1'b1;
                        result_valid_reg <= 1'b1;
                        state_reg        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall must rise in the same cycle the mult/div is seen in execute
    assign stall = ((state_reg == ST_IDLE) && is_md)
                 || (state_reg == ST_START)
                 || (state_reg == ST_BUSY);

    assign md_a         = md_a_reg;
    assign md_b         = md_b_reg;
    assign ctrl_mult    = ctrl_mult_reg;
    assign ctrl_div     = ctrl_div_reg;
    assign result_valid = result_valid_reg;
    assign result       = result_reg;
    assign exception    = exception_reg;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl with a queue of expected completions.
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] insn_x = '0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [31:0] md_result = '0;
    logic        md_exception = 1'b0;
    logic        md_ready = 1'b0;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;
    logic        exception;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          busy;
    } exp_t;
    exp_t sb[$];

    multdiv_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .insn_x       (insn_x),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_ready     (md_ready),
        .md_a         (md_a),
        .md_b         (md_b),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .stall        (stall),
        .result_valid (result_valid),
        .result       (result),
        .exception    (exception)
    );

    always #5 clock = ~clock;

    localparam logic [31:0] INSN_MULT = {5'b00000, 5'd3, 5'd1, 5'd2, 5'd0, 5'b00110, 2'b00};
    localparam logic [31:0] INSN_DIV  = {5'b00000, 5'd4, 5'd5, 5'd6, 5'd0, 5'b00111, 2'b00};
    localparam logic [31:0] INSN_NOP  = 32'h0000_0000;
    localparam logic [31:0] INSN_ITYP = 32'h2800_0018;   // opcode != 0, [6:2]=00110
    localparam logic [31:0] INSN_ADD  = {5'b00000, 5'd1, 5'd2, 5'd3, 5'd0, 5'b00000, 2'b00};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        insn_x = INSN_NOP;
        tick();
        tick();
        checks++;
        if (stall !== 1'b0 || ctrl_mult !== 1'b0 || ctrl_div !== 1'b0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: stall=%b mult=%b div=%b rv=%b required all 0", stall, ctrl_mult, ctrl_div, result_valid);
        end
        checks++;
        if (md_a !== 32'd0 || md_b !== 32'd0 || result !== 32'd0 || exception !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: md_a=%h md_b=%h result=%h exc=%b required 0", md_a, md_b, result, exception);
        end
        // While held in reset, IDLE still decodes a mult combinationally
        insn_x = INSN_MULT;
        tick();
        checks++;
        if (stall !== 1'b1 || ctrl_mult !== 1'b0) begin
            failures++;
            $display("FAIL reset_decode: stall=%b mult=%b required stall=1 mult=0", stall, ctrl_mult);
        end
        insn_x = INSN_NOP;
        reset  = 1'b0;
        tick();
        $display("reset: done");
    endtask

    task automatic test_non_md();
        logic [31:0] list [3];
        list[0] = INSN_NOP;
        list[1] = INSN_ITYP;
        list[2] = INSN_ADD;
        for (int i = 0; i < 3; i++) begin
            insn_x = list[i];
            #1;
            checks++;
            if (stall !== 1'b0) begin
                failures++;
                $display("FAIL non_md_stall: insn=%h stall=%b required 0", list[i], stall);
            end
            tick();
            checks++;
            if (ctrl_mult !== 1'b0 || ctrl_div !== 1'b0 || stall !== 1'b0 || result_valid !== 1'b0) begin
                failures++;
                $display("FAIL non_md_ctrl: insn=%h mult=%b div=%b stall=%b rv=%b required 0", list[i], ctrl_mult, ctrl_div, stall, result_valid);
            end
            $display("non_md: insn=%h no activity", list[i]);
        end
        insn_x = INSN_NOP;
    endtask

    // Run one mult/div from IDLE to the cycle after DONE. lat = BUSY cycle in
    // which md_ready is driven (0 = never). next_insn is placed in X during DONE.
    task automatic run_op(input string name, input logic [31:0] insn, input logic exp_div,
                          input logic [31:0] a, input logic [31:0] b, input int lat,
                          input logic [31:0] mres, input logic mexc, input logic early,
                          input logic [31:0] next_insn, input logic next_is_md);
        exp_t e;
        exp_t got;
        int   busy;
        logic done;
        insn_x = insn;
        operand_a = a;
        operand_b = b;
        md_ready = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1 || ctrl_mult !== 1'b0 || ctrl_div !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: stall=%b mult=%b div=%b required 1/0/0", name, stall, ctrl_mult, ctrl_div);
        end
        if (lat >= 1 && lat <= 64) begin
            e.res = mres; e.exc = mexc; e.busy = lat;
        end else begin
            e.res = 32'd0; e.exc = 1'b1; e.busy = 64;
        end
        sb.push_back(e);
        tick();
        // START
        checks++;
        if (ctrl_mult !== !exp_div || ctrl_div !== exp_div || stall !== 1'b1) begin
            failures++;
            $display("FAIL %s_start: mult=%b div=%b stall=%b required mult=%b div=%b stall=1", name, ctrl_mult, ctrl_div, stall, !exp_div, exp_div);
        end
        checks++;
        if (md_a !== a || md_b !== b) begin
            failures++;
            $display("FAIL %s_latch: md_a=%h md_b=%h required %h %h", name, md_a, md_b, a, b);
        end
        operand_a = 32'h5A5A_5A5A;
        operand_b = 32'hA5A5_A5A5;
        if (early) begin
            md_ready = 1'b1;
            md_result = 32'hBAD0_BAD0;
            md_exception = 1'b1;
        end
        tick();
        md_ready = 1'b0;
        busy = 0;
        done = 1'b0;
        for (int n = 1; n <= 80 && !done; n++) begin
            busy = n;
            checks++;
            if (stall !== 1'b1 || ctrl_mult !== 1'b0 || ctrl_div !== 1'b0 || result_valid !== 1'b0 || md_a !== a || md_b !== b) begin
                failures++;
                $display("FAIL %s_busy: cyc=%0d stall=%b mult=%b div=%b rv=%b md_a=%h md_b=%h required 1/0/0/0 %h %h",
                         name, n, stall, ctrl_mult, ctrl_div, result_valid, md_a, md_b, a, b);
            end
            if (n == lat) begin
                md_ready = 1'b1;
                md_result = mres;
                md_exception = mexc;
            end
            tick();
            md_ready = 1'b0;
            md_exception = 1'b0;
            if (result_valid === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_done_timeout: result_valid=0 after 80 busy cycles required 1", name);
        end else if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s_sb_empty: result_valid with no expected entry", name);
        end else begin
            got = sb.pop_front();
            if (result !== got.res || exception !== got.exc || busy !== got.busy || stall !== 1'b0) begin
                failures++;
                $display("FAIL %s_result: result=%h exc=%b busy=%0d stall=%b required %h %b %0d 0",
                         name, result, exception, busy, stall, got.res, got.exc, got.busy);
            end
            checks++;
            if (md_a !== a || md_b !== b) begin
                failures++;
                $display("FAIL %s_done_hold: md_a=%h md_b=%h required %h %h", name, md_a, md_b, a, b);
            end
        end
        // md_ready in DONE must be ignored; next instruction arrives in X
        insn_x = next_insn;
        md_ready = 1'b1;
        md_result = 32'hDEAD_BEEF;
        md_exception = ~e.exc;
        tick();
        md_ready = 1'b0;
        md_exception = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || result !== e.res || exception !== e.exc ||
            stall !== next_is_md || ctrl_mult !== 1'b0 || ctrl_div !== 1'b0) begin
            failures++;
            $display("FAIL %s_after: rv=%b result=%h exc=%b stall=%b mult=%b div=%b required 0 %h %b %b 0 0",
                     name, result_valid, result, exception, stall, ctrl_mult, ctrl_div, e.res, e.exc, next_is_md);
        end
        $display("%s: a=%h b=%h busy=%0d result=%h exc=%b", name, a, b, busy, result, exception);
    endtask

    task automatic test_mult();
        logic [31:0] p;
        p = 32'd7 * 32'hFFFF_FFFD;   // 7 * -3
        run_op("mult", INSN_MULT, 1'b0, 32'd7, 32'hFFFF_FFFD, 32, p, 1'b0, 1'b0, INSN_NOP, 1'b0);
        checks++;
        if (p !== 32'hFFFF_FFEB || result !== 32'hFFFF_FFEB) begin
            failures++;
            $display("FAIL mult_value: result=%h required FFFFFFEB", result);
        end
    endtask

    task automatic test_div_zero();
        run_op("div0", INSN_DIV, 1'b1, 32'd100, 32'd0, 5, 32'd0, 1'b1, 1'b0, INSN_NOP, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_mult", INSN_MULT, 1'b0, 32'd12, 32'd11, 3, 32'd132, 1'b0, 1'b0, INSN_DIV, 1'b1);
        run_op("b2b_div", INSN_DIV, 1'b1, 32'd144, 32'd12, 8, 32'd12, 1'b0, 1'b0, INSN_NOP, 1'b0);
    endtask

    task automatic test_timeout();
        run_op("timeout", INSN_DIV, 1'b1, 32'd9, 32'd3, 0, 32'd3, 1'b0, 1'b0, INSN_NOP, 1'b0);
    endtask

    task automatic test_ready_at_terminal();
        run_op("ready_tc", INSN_MULT, 1'b0, 32'd5, 32'd6, 64, 32'd30, 1'b0, 1'b0, INSN_NOP, 1'b0);
    endtask

    task automatic test_early_ready();
        run_op("early", INSN_MULT, 1'b0, 32'd3, 32'd4, 2, 32'd12, 1'b0, 1'b1, INSN_NOP, 1'b0);
    endtask

    task automatic test_reset_busy();
        insn_x = INSN_MULT;
        operand_a = 32'h0000_1234;
        operand_b = 32'h0000_5678;
        tick();   // START
        tick();   // BUSY cycle 1
        for (int n = 1; n < 10; n++) tick();
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL rst_busy_pre: stall=%b required 1", stall);
        end
        reset  = 1'b1;
        insn_x = INSN_NOP;
        tick();
        reset = 1'b0;
        checks++;
        if (stall !== 1'b0 || result_valid !== 1'b0 || md_a !== 32'd0 || md_b !== 32'd0 ||
            result !== 32'd0 || exception !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy: stall=%b rv=%b md_a=%h md_b=%h result=%h exc=%b required all 0",
                     stall, result_valid, md_a, md_b, result, exception);
        end
        md_ready = 1'b1;
        md_result = 32'hCAFE_F00D;
        md_exception = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (result_valid !== 1'b0 || stall !== 1'b0 || result !== 32'd0 || exception !== 1'b0) begin
                failures++;
                $display("FAIL rst_ignore_ready: cyc=%0d rv=%b stall=%b result=%h exc=%b required 0", n, result_valid, stall, result, exception);
            end
        end
        md_ready = 1'b0;
        md_exception = 1'b0;
        $display("reset_in_busy: returned to idle");
    endtask

    initial begin
        test_reset();
        test_non_md();
        test_mult();
        test_div_zero();
        test_back_to_back();
        test_timeout();
        test_ready_at_terminal();
        test_early_ready();
        test_reset_busy();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: entries=%0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have port: clock  input  1  master clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: insn_x  input  32  instruction in execute stage.
REQ-004 SHALL have port: operand_a  input  32  execute-stage rs value.
REQ-005 SHALL have port: operand_b  input  32  execute-stage rt value.
REQ-006 SHALL have port: md_result  input  32  multdiv unit result.
REQ-007 SHALL have port: md_exception  input  1  multdiv exception (overflow, divide by zero).
REQ-008 SHALL have port: md_ready  input  1  multdiv result ready.
REQ-009 SHALL have port: md_a  output  32  latched operand A to multdiv.
REQ-010 SHALL have port: md_b  output  32  latched operand B to multdiv.
REQ-011 SHALL have port: ctrl_mult  output  1  one-cycle multiply start pulse.
REQ-012 SHALL have port: ctrl_div  output  1  one-cycle divide start pulse.
REQ-013 SHALL have port: stall  output  1  freeze PC, F/D and D/X latches; bubble into X/M.
REQ-014 SHALL have port: result_valid  output  1  result/exception valid for X/M capture.
REQ-015 SHALL have port: result  output  32  captured product/quotient.
REQ-016 SHALL have port: exception  output  1  captured exception; drives rstatus write.

Function
REQ-017 SHALL decode is_mult = (insn_x[31:27]==00000) & (insn_x[6:2]==00110), and is_div = (insn_x[31:27]==00000) & (insn_x[6:2]==00111).
REQ-018 SHALL implement FSM states IDLE, START, BUSY, DONE.
REQ-019 IDLE: on is_mult|is_div SHALL latch operand_a/operand_b into md_a/md_b and latch the op type, then go to START; otherwise stay in IDLE.
REQ-020 START: SHALL assert ctrl_mult or ctrl_div (per latched op) for exactly one cycle, clear the cycle counter, then go to BUSY.
REQ-021 BUSY: SHALL increment the 6-bit cycle counter each cycle.
REQ-022 BUSY: on md_ready SHALL capture md_result/md_exception into result/exception, then go to DONE.
REQ-023 BUSY: if the counter equals 63 and md_ready=0, SHALL set result=0 and exception=1, then go to DONE.
REQ-024 If md_ready=1 and counter=63 in the same cycle, md_ready SHALL win.
REQ-025 md_ready SHALL be ignored outside BUSY.
REQ-026 DONE: SHALL assert result_valid for exactly one cycle with stall=0, then go to IDLE unconditionally.
REQ-027 stall SHALL be combinational: (IDLE & (is_mult|is_div)) | START | BUSY.
REQ-028 A non-multdiv insn_x SHALL never assert stall, ctrl_mult or ctrl_div.
REQ-029 md_a/md_b SHALL hold constant from START through DONE.
REQ-030 Back-to-back multdiv insns SHALL be supported: the new insn_x is detected in the IDLE cycle following DONE.
REQ-031 result/exception SHALL hold their values until the next capture.

Reset
REQ-032 On reset=1 at a rising edge, from any state including BUSY, the FSM SHALL go to IDLE, with counter=0, md_a=md_b=0, result=0, exception=0.
REQ-033 During and after reset, ctrl_mult, ctrl_div and result_valid SHALL be 0, and stall SHALL be 0 unless IDLE decodes a multdiv insn.

Structure
REQ-034 A shared package SHALL hold: opcode constants (R-type 00000), ALU op codes (MUL 00110, DIV 00111), state encoding, and MD_TIMEOUT=63.
REQ-035 The cycle counter SHALL be a sub-module md_cycle_counter (6-bit, sync clear, enable, terminal-count flag); all else is inline.

Verification
REQ-036 mult 7*(-3), model md_ready after 32 BUSY cycles -> ctrl_mult single pulse in START; stall high from the IDLE-detect cycle through BUSY; in DONE, result_valid=1, result=0xFFFFFFEB, exception=0.
REQ-037 div 100/0, model md_exception=1 -> ctrl_div single pulse; result_valid=1 with exception=1; ctrl_mult=0 throughout.
REQ-038 mult then div back-to-back -> two independent sequences; one IDLE cycle between DONE and the next START; md_a/md_b reload correctly.
REQ-039 md_ready never asserted -> after 63 BUSY cycles, DONE with result=0 and exception=1; stall released.
REQ-040 reset=1 in BUSY cycle 10 -> next cycle IDLE; stall=0 (non-multdiv insn_x); no result_valid; later md_ready ignored.
REQ-041 md_ready=1 during START, then normal completion in BUSY -> the early pulse is ignored; the result is taken from the BUSY-cycle md_ready.
